pipe_sequencer: RTL and testbench

Central pipeline controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Inputs: main control decoder's branch/jump outputs, pipeline-register fields, data-memory handshake.
- Generates PC/IF-ID write enables, IF-ID flush, ID-EX bubble and whole-pipe freeze.
- Sequences multi-cycle data-memory accesses with a timeout, and keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/hazard_detect.sv | 33 +++
 rtl/pipe_sequencer.sv | 138 +++++++++++++
 tb/tb_pipe_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer slice.
//   state_t  : sequencer state encoding (IDLE, RUN, MEM_WAIT, ERROR)
//   REG_ZERO : architectural register $0, which is hardwired to zero and
//              therefore can never be the source of a load-use hazard.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   ifid_rs, ifid_rt : source register fields of the instruction in IF/ID
//   idex_memread     : instruction in ID/EX is a load
//   idex_rt          : destination register of that load
//   hazard           : the IF/ID instruction reads the register the load is
//                      still fetching, so it must wait one cycle
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    output logic       hazard
);

    logic [4:0] rs_bit_eq;
    logic [4:0] rt_bit_eq;

    // Bitwise equality of the load destination against each source field.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_cmp
            assign rs_bit_eq[gi] = ~(idex_rt[gi] ^ ifid_rs[gi]);
            assign rt_bit_eq[gi] = ~(idex_rt[gi] ^ ifid_rt[gi]);
        end
    endgenerate

    assign hazard = idex_memread
                 && (idex_rt != REG_ZERO)
                 && ((&rs_bit_eq) || (&rt_bit_eq));

endmodule

// File: rtl/pipe_sequencer.sv
// Central pipeline controller for the 5-stage MIPS core.
// Produces PC / IF-ID write enables, IF-ID flush, ID-EX bubble and a
// whole-pipe freeze; sequences multi-cycle data-memory accesses with a
// timeout and keeps a saturating stall-cycle counter.
// Ports:
//   clk_i, rst_i (synchronous, active-low), start_i
//   ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i : hazard inputs
//   branch_taken_i, jump_i                          : redirect requests
//   exmem_memreq_i, dmem_ack_i                      : data-memory handshake
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o
//   dmem_req_o, error_o (sticky), stall_cnt_o
// Outputs are combinational from the registered state and current inputs.
module pipe_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             exmem_memreq_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_stall_o,
    output logic             dmem_req_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [7:0]       TIMEOUT_W = 8'(TIMEOUT);
    localparam logic [7:0]       WAIT_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    state_t           state_next;
    logic [7:0]       wait_reg;
    logic [7:0]       wait_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             load_use;
    logic             count_stall;

    hazard_detect u_hazard (
        .ifid_rs      (ifid_rs_i),
        .ifid_rt      (ifid_rt_i),
        .idex_memread (idex_memread_i),
        .idex_rt      (idex_rt_i),
        .hazard       (load_use)
    );

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_stall_o  = 1'b0;
        dmem_req_o    = 1'b0;
        error_o       = 1'b0;
        state_next    = state_reg;
        wait_next     = wait_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                dmem_req_o = exmem_memreq_i;
                if (exmem_memreq_i && !dmem_ack_i) begin
                    // Access not completed this cycle: freeze everything.
                    // This cycle counts as the first waited cycle.
                    pipe_stall_o = 1'b1;
                    wait_next    = WAIT_ONE;
                    state_next   = ST_MEM_WAIT;
                end else if (load_use) begin
                    // Hold PC and IF/ID; a pending branch/jump is simply
                    // re-evaluated next cycle, so no flush here.
                    idex_bubble_o = 1'b1;
                end else begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    ifid_flush_o = branch_taken_i || jump_i;
                end
            end

            ST_MEM_WAIT: begin
                dmem_req_o   = 1'b1;
                pipe_stall_o = 1'b1;
                if (dmem_ack_i) begin
                    // An ack always wins, even on the timeout cycle.
                    wait_next  = '0;
                    state_next = ST_RUN;
                end else if (wait_reg >= TIMEOUT_W) begin
                    state_next = ST_ERROR;
                end else begin
                    wait_next = wait_reg + WAIT_ONE;
                end
            end

            default: begin
                error_o      = 1'b1;
                pipe_stall_o = 1'b1;
            end
        endcase
    end

    assign count_stall = ((state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT))
                      && !pc_write_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg     <= ST_IDLE;
            wait_reg      <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (count_stall && (stall_cnt_reg != CNT_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_sequencer.sv
module tb_pipe_sequencer;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Reference-model modes (independent of the RTL encoding)
    localparam int M_IDLE = 10;
    localparam int M_RUN  = 11;
    localparam int M_WAIT = 12;
    localparam int M_ERR  = 13;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             exmem_memreq_i;
    logic             dmem_ack_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_stall_o;
    logic             dmem_req_o;
    logic             error_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    int m_mode   = M_IDLE;
    int m_waited = 0;
    int m_stall  = 0;

    always #5 clk_i = ~clk_i;

    pipe_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .exmem_memreq_i (exmem_memreq_i),
        .dmem_ack_i     (dmem_ack_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .pipe_stall_o   (pipe_stall_o),
        .dmem_req_o     (dmem_req_o),
        .error_o        (error_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare every output against the
    // spec-rule model, then advance the model at the clock edge.
    task automatic step(input string tag, input bit chk,
                        input logic rst, input logic st,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] xrt,
                        input logic br, input logic jp,
                        input logic mq, input logic ack);
        bit e_pc, e_ifw, e_fl, e_bub, e_stl, e_req, e_err, hz;
        int n_mode, n_waited, n_stall;
        @(negedge clk_i);
        rst_i = rst; start_i = st; ifid_rs_i = rs; ifid_rt_i = rt;
        idex_memread_i = mr; idex_rt_i = xrt; branch_taken_i = br;
        jump_i = jp; exmem_memreq_i = mq; dmem_ack_i = ack;
        #1;
        hz = mr && (xrt != 5'd0) && ((xrt == rs) || (xrt == rt));
        {e_pc, e_ifw, e_fl, e_bub, e_stl, e_req, e_err} = '0;
        n_mode = m_mode; n_waited = m_waited;
        if (m_mode == M_IDLE) begin
            if (st) n_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            e_req = mq;
            if (mq && !ack) begin
                e_stl = 1; n_mode = M_WAIT; n_waited = 1;
            end else if (hz) begin
                e_bub = 1;
            end else begin
                e_pc = 1; e_ifw = 1; e_fl = br | jp;
            end
        end else if (m_mode == M_WAIT) begin
            e_req = 1; e_stl = 1;
            if (ack) begin
                n_mode = M_RUN; n_waited = 0;
            end else if (m_waited >= TIMEOUT) begin
                n_mode = M_ERR;
            end else begin
                n_waited = m_waited + 1;
            end
        end else begin
            e_err = 1; e_stl = 1;
        end
        n_stall = m_stall;
        if ((m_mode == M_RUN || m_mode == M_WAIT) && !e_pc && m_stall < CNT_MAX)
            n_stall = m_stall + 1;

        $display("step %-10s rst=%0b st=%0b mq=%0b ack=%0b hz=%0b br=%0b | pc=%0b ifw=%0b fl=%0b bub=%0b stl=%0b req=%0b err=%0b cnt=%0d",
                 tag, rst, st, mq, ack, hz, br | jp, pc_write_o, ifid_write_o,
                 ifid_flush_o, idex_bubble_o, pipe_stall_o, dmem_req_o, error_o, stall_cnt_o);
        if (chk) begin
            check({tag, ".pc_write"},  32'(pc_write_o),    32'(e_pc));
            check({tag, ".ifid_write"},32'(ifid_write_o),  32'(e_ifw));
            check({tag, ".flush"},     32'(ifid_flush_o),  32'(e_fl));
            check({tag, ".bubble"},    32'(idex_bubble_o), 32'(e_bub));
            check({tag, ".stall"},     32'(pipe_stall_o),  32'(e_stl));
            check({tag, ".dmem_req"},  32'(dmem_req_o),    32'(e_req));
            check({tag, ".error"},     32'(error_o),       32'(e_err));
            check({tag, ".stall_cnt"}, 32'(stall_cnt_o),   32'(m_stall));
        end
        @(posedge clk_i);
        if (!rst) begin
            m_mode = M_IDLE; m_waited = 0; m_stall = 0;
        end else begin
            m_mode = n_mode; m_waited = n_waited; m_stall = n_stall;
        end
    endtask

    // Convenience wrappers for common RUN-mode patterns
    task automatic idle_step(input string tag, input logic st);
        step(tag, 1, 1, st, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic mem_step(input string tag, input logic ack);
        step(tag, 1, 1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, ack);
    endtask

    task automatic do_reset();
        step("reset", 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset and start
        step("reset0", 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) idle_step("idle", 0);
        idle_step("start", 1);
        idle_step("run", 0);
        check("run_pc_write", 32'(pc_write_o), 32'd1);

        // Load-use hazard on rs and rt; $0 never hazards
        step("lu_rs", 1, 1, 0, 5'd8, 5'd3, 1, 5'd8, 0, 0, 0, 0);
        step("lu_rt", 1, 1, 0, 5'd4, 5'd9, 1, 5'd9, 0, 0, 0, 0);
        step("lu_zero", 1, 1, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0);
        check("lu_cnt", 32'(stall_cnt_o), 32'd2);

        // Redirects with and without a hazard
        step("branch", 1, 1, 0, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0, 0);
        step("jump", 1, 1, 0, 5'd1, 5'd2, 1, 5'd7, 0, 1, 0, 0);
        step("br_hz", 1, 1, 0, 5'd7, 5'd2, 1, 5'd7, 1, 0, 0, 0);

        // Memory wait: ack low for 3 cycles, then high
        mem_step("mw_req", 0);
        mem_step("mw_wait", 0);
        mem_step("mw_wait", 0);
        mem_step("mw_ack", 1);
        idle_step("mw_after", 0);
        check("mw_cnt", 32'(stall_cnt_o), 32'd7);
        mem_step("mw_fast", 1);

        // Timeout into ERROR, freeze persists, reset clears
        mem_step("to_req", 0);
        for (int i = 0; i < TIMEOUT; i++) mem_step("to_wait", 0);
        mem_step("to_err", 1);
        check("to_error_flag", 32'(error_o), 32'd1);
        idle_step("to_err2", 1);
        do_reset();
        idle_step("post_rst", 0);

        // Ack on the very cycle the timeout is reached
        idle_step("start", 1);
        mem_step("edge_req", 0);
        for (int i = 0; i < TIMEOUT - 1; i++) mem_step("edge_wait", 0);
        mem_step("edge_ack", 1);
        idle_step("edge_run", 0);

        // Reset in the middle of MEM_WAIT
        mem_step("mid_req", 0);
        mem_step("mid_wait", 0);
        step("mid_rst", 1, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        idle_step("mid_idle", 0);

        // Saturation: 20 consecutive load-use stalls
        idle_step("start", 1);
        for (int i = 0; i < 20; i++)
            step("sat", 1, 1, 0, 5'd5, 5'd6, 1, 5'd5, 0, 0, 0, 0);
        idle_step("sat_end", 0);
        check("sat_hold", 32'(stall_cnt_o), 32'(CNT_MAX));

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic r_rst, r_st, r_mr, r_br, r_jp, r_mq, r_ack;
            logic [4:0] r_rs, r_rt, r_xrt;
            r_rst = ($urandom_range(0, 99) >= 3);
            r_st  = ($urandom_range(0, 99) < 30);
            r_rs  = 5'($urandom_range(0, 3));
            r_rt  = 5'($urandom_range(0, 3));
            r_xrt = 5'($urandom_range(0, 3));
            r_mr  = ($urandom_range(0, 99) < 40);
            r_br  = ($urandom_range(0, 99) < 20);
            r_jp  = ($urandom_range(0, 99) < 10);
            r_mq  = ($urandom_range(0, 99) < 25);
            r_ack = ($urandom_range(0, 99) < 35);
            step("rand", 1, r_rst, r_st, r_rs, r_rt, r_mr, r_xrt, r_br, r_jp, r_mq, r_ack);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
